uart_pkt_tx: RTL and testbench
==============================

// Module: uart_pkt_tx
// PURPOSE
//  Packet framer driving the byte-transmit handshake of the UART block. Host loads
//  payload into an internal FIFO, pulses send; block emits SYNC, LEN, payload, CRC-8
//  one byte at a time on u_byte/u_transmit, pacing on u_transmited.
//  Sits between the host/control logic and the UART transmitter.
// PARAMETERS
//  SYNC   8'hA5  frame start byte
//  DEPTH  16     payload FIFO depth in bytes (power of 2, <=128)
//  AW     4      log2(DEPTH)
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  rst          in   1     reset, asynchronous, active-high
//  wr_en        in   1     payload write strobe
//  wr_data      in   8     payload byte
//  full         out  1     FIFO holds DEPTH bytes
//  wr_drop      out  1     1-cycle pulse: write ignored (full or busy)
//  send         in   1     start-of-frame request (1-cycle pulse)
//  busy         out  1     frame in progress
//  done         out  1     1-cycle pulse after CRC byte acknowledged
//  u_byte       out  8     byte to UART (t_byte)
//  u_transmit   out  1     1-cycle request to UART (transmit)
//  u_transmited in   1     UART 1-cycle byte-complete pulse (transmited)
// BEHAVIOUR
//  Reset: all outputs 0 (u_byte=0), FIFO empty, CRC=0, state IDLE. Reset mid-frame
//   aborts immediately; no further u_transmit; UART finishes its current byte alone.
//  FIFO: wr_en accepted only when !busy && !full; otherwise wr_drop pulses next cycle.
//   count is AW+1 bits, 0..DEPTH; pointers wrap modulo DEPTH.
//  States: IDLE -> SYNC -> LEN -> DATA -> CRC -> IDLE. Each byte state has two phases:
//   ISSUE: u_byte set, u_transmit=1 for exactly one cycle; then WAIT: u_transmit=0,
//   u_byte held stable until u_transmited seen. Next ISSUE is the cycle after that.
//  IDLE: send=1 -> latch len=count, clear CRC, busy=1 next cycle, enter SYNC/ISSUE.
//   send while busy is ignored. send with count=0 is legal.
//  SYNC: byte = SYNC param; not included in CRC.
//  LEN: byte = len (zero-extended to 8 bits); CRC updated with it at ISSUE.
//  DATA: byte = FIFO head; pop and CRC update at ISSUE; repeat len times; len=0 skips
//   DATA entirely (LEN -> CRC).
//  CRC: byte = CRC register. On its u_transmited: done=1 one cycle, busy=0 same cycle,
//   state IDLE. New writes accepted from that cycle on.
//  CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, byte-parallel
//   combinational update (one byte per cycle).
//  u_transmited in IDLE or during ISSUE: ignored. wr_en and send same cycle in IDLE:
//   write is dropped (wr_drop), frame uses pre-write count.
//  Frame bytes on wire per frame: len+3. No timeout on u_transmited.
// TESTING
//  1. write 01,02; send -> u_byte sequence A5,02,01,02,CD; done once; busy low after.
//  2. empty FIFO; send -> A5,00,00; done pulses; no DATA state entered.
//  3. write 17 bytes with DEPTH=16 -> full=1 after 16th; 17th gives wr_drop; frame LEN=10h.
//  4. wr_en during busy -> wr_drop, count unchanged; send during busy -> ignored, one frame.
//  5. assert rst while in DATA WAIT -> outputs 0, full=0, no further u_transmit; new frame
//     after release works as test 1.
//  6. delay u_transmited 0..200 cycles randomly -> u_byte stable in WAIT, exactly one
//     u_transmit per byte, byte order and CRC match model.

Source files
------------

// File: rtl/uart_pkt_tx.sv
// Packet framer: buffers payload bytes in a FIFO, then emits SYNC, LEN, payload, CRC-8
// one byte at a time over the UART byte handshake.
module uart_pkt_tx #(
    parameter logic [7:0] SYNC  = 8'hA5,
    parameter int         DEPTH = 16,
    parameter int         AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       wr_drop,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic [7:0] u_byte,
    output logic       u_transmit,
    input  logic       u_transmited
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CRC
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   rem;
    logic [7:0]    crc;
    logic [7:0]    head;
    logic          wr_ok;
    logic          byte_ack;
    logic          pop;

    // CRC-8, poly 0x07, MSB first, one whole byte per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // A write racing a send in IDLE is dropped so the frame length stays the pre-write count.
    assign full     = (count == CNT_FULL);
    assign wr_ok    = wr_en && !busy && !full && !send;
    assign byte_ack = u_transmited && !u_transmit && (state != S_IDLE);
    assign pop      = byte_ack && ((state == S_LEN) || (state == S_DATA)) && (rem != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && !wr_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok) begin
                count <= count + CNT_ONE;
            end else if (pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Loading u_byte with u_transmit=1 opens ISSUE; the following cycles are WAIT until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rem        <= '0;
            crc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            u_byte     <= '0;
            u_transmit <= 1'b0;
        end else begin
            u_transmit <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (send) begin
                        state      <= S_SYNC;
                        rem        <= count;
                        crc        <= '0;
                        busy       <= 1'b1;
                        u_byte     <= SYNC;
                        u_transmit <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (byte_ack) begin
                        state      <= S_LEN;
                        u_byte     <= 8'(rem);
                        crc        <= crc8_next(crc, 8'(rem));
                        u_transmit <= 1'b1;
                    end
                end
                S_LEN, S_DATA: begin
                    if (byte_ack) begin
                        u_transmit <= 1'b1;
                        if (rem == '0) begin
                            state  <= S_CRC;
                            u_byte <= crc;
                        end else begin
                            state  <= S_DATA;
                            u_byte <= head;
                            crc    <= crc8_next(crc, head);
                            rem    <= rem - CNT_ONE;
                        end
                    end
                end
                S_CRC: begin
                    if (byte_ack) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed + randomized bench for uart_pkt_tx with a queue-based frame model and a UART responder.
module tb_uart_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       wr_drop;
    logic       send;
    logic       busy;
    logic       done;
    logic [7:0] u_byte;
    logic       u_transmit;
    logic       u_transmited;

    always #5 clk = ~clk;

    uart_pkt_tx #(.SYNC(8'hA5), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .wr_drop(wr_drop), .send(send), .busy(busy), .done(done), .u_byte(u_byte),
        .u_transmit(u_transmit), .u_transmited(u_transmited)
    );

    int checks = 0;
    int failures = 0;
    int ntx = 0;
    int ndone = 0;
    int stable_err = 0;
    int max_delay = 3;
    bit in_frame = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: bit-serial long division over the message, MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic fb;
        r = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            if (u_transmit === 1'b1) ntx++;
        end
    end

    // UART model: accepts one byte per request, acknowledges after a random delay.
    initial begin
        logic [7:0] cap;
        int d;
        u_transmited = 1'b0;
        @(posedge clk); #1;
        forever begin
            if (u_transmit === 1'b1 && rst === 1'b0) begin
                cap = u_byte;
                rx_q.push_back(cap);
                d = int'($urandom_range(max_delay, 0));
                @(posedge clk); #1;
                if (!rst && (u_byte !== cap || u_transmit !== 1'b0)) stable_err++;
                repeat (d) begin
                    @(posedge clk); #1;
                    if (!rst && (u_byte !== cap || u_transmit !== 1'b0)) stable_err++;
                end
                u_transmited = 1'b1;
                @(posedge clk); #1;
                u_transmited = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        bit exp_drop;
        exp_drop = in_frame || (model_q.size() >= 16);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
        if (!exp_drop) model_q.push_back(d);
        if (!in_frame) chk("full", 32'(full), 32'(model_q.size() == 16));
    endtask

    task automatic start_frame(input bit with_write, input logic [7:0] d);
        logic [7:0] body[$];
        body = {8'(model_q.size()), model_q};
        exp_q = {8'hA5, body, ref_crc(body)};
        model_q.delete();
        rx_q.delete();
        ntx = 0;
        ndone = 0;
        stable_err = 0;
        @(negedge clk);
        send = 1'b1;
        wr_en = with_write;
        wr_data = d;
        @(negedge clk);
        send = 1'b0;
        wr_en = 1'b0;
        in_frame = 1'b1;
        chk("busy_start", 32'(busy), 32'd1);
        if (with_write) chk("wr_drop_with_send", 32'(wr_drop), 32'd1);
    endtask

    task automatic finish_frame(input string tag);
        int t;
        t = 0;
        while (ndone == 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 32'(ndone != 0), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        in_frame = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        chk({tag, "_ntransmit"}, 32'(ntx), 32'(exp_q.size()));
        chk({tag, "_stable"}, 32'(stable_err), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxx, 32'(exp_q[i]));
        end
    endtask

    initial begin
        int len;
        int t;
        int ntx_snap;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        send = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_u_byte", 32'(u_byte), 32'd0);
        chk("rst_u_transmit", 32'(u_transmit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-byte frame: A5 02 01 02 CD
        write_byte(8'h01);
        write_byte(8'h02);
        start_frame(1'b0, 8'h00);
        chk("t1_crc_model", 32'(exp_q[4]), 32'hCD);
        finish_frame("t1");

        // Fill past depth
        for (int i = 0; i < 17; i++) write_byte(8'($urandom));
        chk("t3_full", 32'(full), 32'd1);
        start_frame(1'b0, 8'h00);
        chk("t3_len", 32'(exp_q[1]), 32'h10);
        finish_frame("t3");
        chk("t3_full_after", 32'(full), 32'd0);

        // Writes and send while busy are ignored
        for (int i = 0; i < 3; i++) write_byte(8'($urandom));
        start_frame(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        write_byte(8'h5A);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        finish_frame("t4");

        // Write coinciding with send is dropped; frame uses pre-write count
        write_byte(8'h33);
        write_byte(8'h44);
        start_frame(1'b1, 8'h99);
        finish_frame("t4b");

        // Empty frame: A5 00 00
        start_frame(1'b0, 8'h00);
        finish_frame("t2");

        // Reset during DATA WAIT
        max_delay = 5;
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        start_frame(1'b0, 8'h00);
        t = 0;
        while (!(rx_q.size() >= 3 && u_transmit === 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("t5_reached_data", 32'(rx_q.size()), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_rst_u_byte", 32'(u_byte), 32'd0);
        chk("t5_rst_u_transmit", 32'(u_transmit), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_full", 32'(full), 32'd0);
        ntx_snap = ntx;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_frame = 1'b0;
        model_q.delete();
        repeat (15) @(negedge clk);
        chk("t5_no_more_transmit", 32'(ntx), 32'(ntx_snap));
        chk("t5_idle_busy", 32'(busy), 32'd0);
        write_byte(8'h01);
        write_byte(8'h02);
        start_frame(1'b0, 8'h00);
        finish_frame("t5_after");

        // Random payloads with long, random acknowledge delays
        max_delay = 200;
        for (int f = 0; f < 3; f++) begin
            len = int'($urandom_range(16, 0));
            for (int i = 0; i < len; i++) write_byte(8'($urandom));
            start_frame(1'b0, 8'h00);
            finish_frame($sformatf("t6_f%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
